regfile_wb_sched: RTL

- Write-back scheduler for the LC-3 8x16 register file. Two producers share the file's single write port: ALU/execute results and memory-load results.
- Arbitrates between them round-robin and drives the file's ld_reg/DR/global write inputs from registers.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on SR1/SR2 and stall.

---
 rtl/regfile_wb_sched.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the 8x16 register file: round-robin arbitration of ALU and
// load results onto the single write port, plus a per-register pending-write scoreboard.
module regfile_wb_sched #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [2:0]        alu_dr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [2:0]        mem_dr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [2:0]        issue_dr,
    output logic              issue_ready,
    input  logic [2:0]        sr1,
    input  logic [2:0]        sr2,
    output logic              sr1_busy,
    output logic              sr2_busy,
    output logic              rf_ld_reg,
    output logic [2:0]        rf_dr,
    output logic [DATA_W-1:0] rf_global,
    output logic              wb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

    src_t              r_last_grant;
    src_t              w_last_grant_nxt;
    logic              r_ld_reg;
    logic [2:0]        r_dr;
    logic [DATA_W-1:0] r_global;
    logic              r_err;
    logic [CNT_W-1:0]  r_pending [8];
    logic [CNT_W-1:0]  w_pending_nxt [8];
    logic              w_grant_alu;
    logic              w_grant_mem;
    logic              w_issue_acc;
    logic              w_err_set;
    logic [7:0]        w_inc;
    logic [7:0]        w_dec;

    // Grant arbitration; on a tie the source that did not win last time goes first.
    always_comb begin
        w_grant_alu      = 1'b0;
        w_grant_mem      = 1'b0;
        w_last_grant_nxt = r_last_grant;
        if (alu_valid && (!mem_valid || r_last_grant == SRC_MEM)) begin
            w_grant_alu      = 1'b1;
            w_last_grant_nxt = SRC_ALU;
        end else if (mem_valid) begin
            w_grant_mem      = 1'b1;
            w_last_grant_nxt = SRC_MEM;
        end
    end

    assign alu_ready   = w_grant_alu;
    assign mem_ready   = w_grant_mem;
    assign issue_ready = (r_pending[issue_dr] != CNT_MAX);
    assign w_issue_acc = issue_valid && issue_ready;
    assign w_inc       = w_issue_acc ? (8'b1 << issue_dr) : 8'b0;
    assign w_dec       = r_ld_reg ? (8'b1 << r_dr) : 8'b0;
    assign sr1_busy    = (r_pending[sr1] != CNT_ZERO);
    assign sr2_busy    = (r_pending[sr2] != CNT_ZERO);

    // An issue and a write-back to the same register in one cycle cancel out.
    always_comb begin
        w_err_set = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_pending_nxt[i] = r_pending[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_pending_nxt[i] = r_pending[i] + CNT_ONE;
            end else if (w_dec[i] && !w_inc[i]) begin
                if (r_pending[i] == CNT_ZERO) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pending_nxt[i] = r_pending[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= SRC_MEM;
            r_ld_reg     <= 1'b0;
            r_dr         <= 3'd0;
            r_global     <= '0;
            r_err        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_pending[i] <= CNT_ZERO;
            end
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_ld_reg     <= w_grant_alu || w_grant_mem;
            if (w_grant_alu) begin
                r_dr     <= alu_dr;
                r_global <= alu_data;
            end else if (w_grant_mem) begin
                r_dr     <= mem_dr;
                r_global <= mem_data;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                r_pending[i] <= w_pending_nxt[i];
            end
        end
    end

    assign rf_ld_reg = r_ld_reg;
    assign rf_dr     = r_dr;
    assign rf_global = r_global;
    assign wb_err    = r_err;
endmodule
